// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file widths and index/data types.
package rf_pkg;
    localparam int DATA_W = 16;
    localparam int NREG = 8;
    localparam int ADDR_W = $clog2(NREG);
    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits with set/clear/flush and a combinational hazard output.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_idx,
    input  logic [ADDR_W-1:0] rd_a,
    input  logic [ADDR_W-1:0] rd_b,
    input  logic              chk_en,
    input  logic [ADDR_W-1:0] chk_idx,
    output logic              haz
);
    logic [NREG-1:0] busy, pend;
    // a writeback in flight this cycle already resolves its register
    assign pend = busy & ~(clr_en ? NREG'(1) << clr_idx : '0);
    assign haz = pend[rd_a] | pend[rd_b] | (chk_en & pend[chk_idx]);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else busy <= flush ? '0 : pend | (set_en ? NREG'(1) << set_idx : '0);
    end
endmodule

// File: rtl/rf_operand_reader.sv
// rf_operand_reader: 8x16 register file read side with busy scoreboard, writeback bypass
// and a registered valid/ready operand stage.
module rf_operand_reader
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic              dest_valid,
    input  logic [ADDR_W-1:0] dest_addr,
    output logic              ops_valid,
    input  logic              ops_ready,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic [15:0]       stall_cnt
);
    data_t regs [NREG];
    data_t byp_a, byp_b;
    logic haz, free, accept, stall;
    rf_scoreboard u_sb (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .set_en(accept & dest_valid), .set_idx(dest_addr),
        .clr_en(wb_we), .clr_idx(wb_addr),
        .rd_a(ra_addr), .rd_b(rb_addr),
        .chk_en(dest_valid), .chk_idx(dest_addr),
        .haz(haz)
    );
    assign free = ~ops_valid | ops_ready;
    assign req_ready = free & ~haz & ~flush;
    assign accept = req_valid & req_ready;
    assign stall = req_valid & free & haz & ~flush;
    assign byp_a = (wb_we && wb_addr == ra_addr) ? wb_data : regs[ra_addr];
    assign byp_b = (wb_we && wb_addr == rb_addr) ? wb_data : regs[rb_addr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            ops_valid <= 1'b0;
            ra_data <= '0;
            rb_data <= '0;
            stall_cnt <= '0;
        end else begin
            if (wb_we) regs[wb_addr] <= wb_data;
            ops_valid <= flush ? 1'b0 : accept ? 1'b1 : ops_ready ? 1'b0 : ops_valid;
            if (accept) begin
                ra_data <= byp_a;
                rb_data <= byp_b;
            end
            if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_rf_operand_reader.sv
// tb_rf_operand_reader: directed vector table, random run against a reference model,
// stall-counter saturation and asynchronous reset checks.
module tb_rf_operand_reader;
    logic clk = 1'b0, rst_n = 1'b0;
    logic flush = 0, wb_we = 0, req_valid = 0, dest_valid = 0, ops_ready = 0;
    logic [2:0] wb_addr = 0, ra_addr = 0, rb_addr = 0, dest_addr = 0;
    logic [15:0] wb_data = 0;
    logic req_ready, ops_valid;
    logic [15:0] ra_data, rb_data, stall_cnt;
    int n_chk = 0, n_pass = 0;

    rf_operand_reader dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .req_valid(req_valid), .req_ready(req_ready),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .dest_valid(dest_valid),
        .dest_addr(dest_addr), .ops_valid(ops_valid), .ops_ready(ops_ready),
        .ra_data(ra_data), .rb_data(rb_data), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic fl, we; logic [2:0] wa; logic [15:0] wd;
        logic rv; logic [2:0] ra, rb; logic dv; logic [2:0] da; logic ordy;
        logic ex_rdy, ex_ov; logic [15:0] ex_a, ex_b, ex_sc;
    } vec_t;
    vec_t tbl [18];

    function automatic vec_t mk(logic fl, logic we, logic [2:0] wa, logic [15:0] wd,
        logic rv, logic [2:0] ra, logic [2:0] rb, logic dv, logic [2:0] da, logic ordy,
        logic ex_rdy, logic ex_ov, logic [15:0] ex_a, logic [15:0] ex_b, logic [15:0] ex_sc);
        vec_t v;
        v.fl = fl; v.we = we; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra; v.rb = rb;
        v.dv = dv; v.da = da; v.ordy = ordy; v.ex_rdy = ex_rdy; v.ex_ov = ex_ov;
        v.ex_a = ex_a; v.ex_b = ex_b; v.ex_sc = ex_sc;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(vec_t v);
        flush = v.fl; wb_we = v.we; wb_addr = v.wa; wb_data = v.wd; req_valid = v.rv;
        ra_addr = v.ra; rb_addr = v.rb; dest_valid = v.dv; dest_addr = v.da; ops_ready = v.ordy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(mk(0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // reference model state
    logic [15:0] m_regs [8];
    bit m_busy [8];
    bit m_ov;
    logic [15:0] m_a, m_b;
    int m_sc;

    function automatic bit m_pending(vec_t v, logic [2:0] r);
        return m_busy[r] && !(v.we && v.wa == r);
    endfunction

    function automatic logic [15:0] m_read(vec_t v, logic [2:0] r);
        return (v.we && v.wa == r) ? v.wd : m_regs[r];
    endfunction

    initial begin
        vec_t v;
        bit haz, free, rdy, acc;
        tbl[0]  = mk(0,1,3,16'h1234, 0,0,0,0,0,1, 1,0,16'h0000,16'h0000,0);
        tbl[1]  = mk(0,0,0,0,        1,3,0,0,0,1, 1,1,16'h1234,16'h0000,0);
        tbl[2]  = mk(0,0,0,0,        1,1,1,1,5,1, 1,1,16'h0000,16'h0000,0);
        tbl[3]  = mk(0,0,0,0,        1,5,0,0,0,1, 0,0,16'h0000,16'h0000,1);
        tbl[4]  = mk(0,1,5,16'hBEEF, 1,5,0,0,0,1, 1,1,16'hBEEF,16'h0000,1);
        tbl[5]  = mk(0,0,0,0,        1,3,5,0,0,0, 0,1,16'hBEEF,16'h0000,1);
        tbl[6]  = mk(0,0,0,0,        1,3,5,0,0,0, 0,1,16'hBEEF,16'h0000,1);
        tbl[7]  = mk(0,0,0,0,        1,3,5,0,0,0, 0,1,16'hBEEF,16'h0000,1);
        tbl[8]  = mk(0,0,0,0,        1,3,5,0,0,1, 1,1,16'h1234,16'hBEEF,1);
        tbl[9]  = mk(0,0,0,0,        1,5,3,0,0,1, 1,1,16'hBEEF,16'h1234,1);
        tbl[10] = mk(0,1,2,16'h2222, 1,0,0,1,2,1, 1,1,16'h0000,16'h0000,1);
        tbl[11] = mk(0,0,0,0,        1,2,0,0,0,1, 0,0,16'h0000,16'h0000,2);
        tbl[12] = mk(0,0,0,0,        1,2,0,0,0,1, 0,0,16'h0000,16'h0000,3);
        tbl[13] = mk(0,1,2,16'h3333, 1,2,0,0,0,1, 1,1,16'h3333,16'h0000,3);
        tbl[14] = mk(0,0,0,0,        1,0,0,1,1,1, 1,1,16'h0000,16'h0000,3);
        tbl[15] = mk(0,0,0,0,        1,0,0,1,4,1, 1,1,16'h0000,16'h0000,3);
        tbl[16] = mk(1,1,1,16'h1111, 1,1,0,0,0,0, 0,0,16'h0000,16'h0000,3);
        tbl[17] = mk(0,0,0,0,        1,1,4,0,0,0, 1,1,16'h1111,16'h0000,3);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_ops_valid", 32'(ops_valid), 0);
        chk("reset_ra_data", 32'(ra_data), 0);
        chk("reset_rb_data", 32'(rb_data), 0);
        chk("reset_stall_cnt", 32'(stall_cnt), 0);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1 chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].ex_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_ops_valid", i), 32'(ops_valid), 32'(tbl[i].ex_ov));
            chk($sformatf("vec%0d_ra_data", i), 32'(ra_data), 32'(tbl[i].ex_a));
            chk($sformatf("vec%0d_rb_data", i), 32'(rb_data), 32'(tbl[i].ex_b));
            chk($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].ex_sc));
        end

        do_reset();
        for (int r = 0; r < 8; r++) begin m_regs[r] = 0; m_busy[r] = 0; end
        m_ov = 0; m_a = 0; m_b = 0; m_sc = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            v = mk($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, 3'($urandom),
                   16'($urandom), $urandom_range(0, 3) != 0, 3'($urandom), 3'($urandom),
                   $urandom_range(0, 1) == 1, 3'($urandom), $urandom_range(0, 3) != 0,
                   0, 0, 0, 0, 0);
            drive(v);
            haz = m_pending(v, v.ra) || m_pending(v, v.rb) || (v.dv && m_pending(v, v.da));
            free = !m_ov || v.ordy;
            rdy = free && !haz && !v.fl;
            acc = v.rv && rdy;
            #1 chk("rand_req_ready", 32'(req_ready), 32'(rdy));
            if (acc) begin m_a = m_read(v, v.ra); m_b = m_read(v, v.rb); end
            if (v.rv && free && haz && !v.fl && m_sc < 65535) m_sc++;
            m_ov = v.fl ? 0 : acc ? 1 : v.ordy ? 0 : m_ov;
            if (v.we) begin m_regs[v.wa] = v.wd; m_busy[v.wa] = 0; end
            if (acc && v.dv) m_busy[v.da] = 1;
            if (v.fl) for (int r = 0; r < 8; r++) m_busy[r] = 0;
            @(posedge clk);
            #1;
            chk("rand_ops_valid", 32'(ops_valid), 32'(m_ov));
            chk("rand_ra_data", 32'(ra_data), 32'(m_a));
            chk("rand_rb_data", 32'(rb_data), 32'(m_b));
            chk("rand_stall_cnt", 32'(stall_cnt), 32'(m_sc));
        end

        do_reset();
        @(negedge clk);
        drive(mk(0,1,3,16'hA5A5, 0,0,0,0,0,1, 0,0,0,0,0));
        @(negedge clk);
        drive(mk(0,0,0,0, 1,3,0,1,6,1, 0,0,0,0,0));
        @(negedge clk);
        drive(mk(0,0,0,0, 1,6,0,0,0,1, 0,0,0,0,0));
        for (int i = 0; i < 70000; i++) @(negedge clk);
        #1;
        chk("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
        chk("sat_req_ready", 32'(req_ready), 0);
        chk("sat_ra_hold", 32'(ra_data), 32'hA5A5);
        #1 rst_n = 1'b0;
        #1;
        chk("async_ops_valid", 32'(ops_valid), 0);
        chk("async_ra_data", 32'(ra_data), 0);
        chk("async_rb_data", 32'(rb_data), 0);
        chk("async_stall_cnt", 32'(stall_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
